// File: rtl/top_6502_system.sv
// Multi-cycle 6502-subset CPU with its ROM/RAM instance `mem`; the ROM sits at the top of the
// address space and the RAM at $0000. Define INSN_TRACE_EN for a simulation-only trace printed on every fetch.

module top_6502_mem #(
  parameter int ROM_WORDS = 4096,
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata
);
  localparam int          ROM_AW   = $clog2(ROM_WORDS);
  localparam int          RAM_AW   = $clog2(RAM_WORDS);
  localparam logic [16:0] ROM_BASE = 17'h10000 - 17'(ROM_WORDS);

  logic [7:0] ROM [0:ROM_WORDS-1];
  logic [7:0] RAM [0:RAM_WORDS-1];
  logic       is_rom_s;
  logic       is_ram_s;

  // Address decode for the two mapped windows
  always_comb begin
    is_rom_s = ({1'b0, addr} >= ROM_BASE);
    is_ram_s = ({1'b0, addr} < 17'(RAM_WORDS));
  end

  // Combinational read; unmapped space reads as zero
  always_comb begin
    if (is_rom_s) begin
      rdata = ROM[addr[ROM_AW-1:0]];
    end else if (is_ram_s) begin
      rdata = RAM[addr[RAM_AW-1:0]];
    end else begin
      rdata = 8'h00;
    end
  end

  // Only RAM accepts writes; RAM contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we && is_ram_s) begin
      RAM[addr[RAM_AW-1:0]] <= wdata;
    end
  end
endmodule

module top_6502_system #(
  parameter int ROM_WORDS = 4096,
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic        halted,
  output logic [15:0] pc_dbg
);
  typedef enum logic [2:0] {VEC_LO, VEC_HI, FETCH, OPER1, OPER2, EXEC, HALT} state_t;

  state_t      state_r, state_nxt;
  logic [15:0] pc_r, pc_nxt;
  logic [7:0]  a_r, a_nxt;
  logic [7:0]  x_r, x_nxt;
  logic [7:0]  y_r, y_nxt;
  logic [7:0]  op_r, op_nxt;
  logic [7:0]  opnd_r, opnd_nxt;
  logic        flag_n_r, flag_n_nxt;
  logic        flag_v_r, flag_v_nxt;
  logic        flag_z_r, flag_z_nxt;
  logic        flag_c_r, flag_c_nxt;
  logic        halted_r, halted_nxt;

  logic [15:0] mem_addr_s;
  logic        mem_we_s;
  logic [7:0]  mem_wdata_s;
  logic [7:0]  mem_rdata_s;
  logic [7:0]  adc_m_s;
  logic [8:0]  adc_sum_s;
  logic        adc_v_s;
  logic [8:0]  cmp_diff_s;
  logic        nz_en_s;
  logic [7:0]  nz_val_s;

  function automatic logic is_imm(input logic [7:0] op);
    case (op)
      8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_zp(input logic [7:0] op);
    case (op)
      8'hA5, 8'h85, 8'h86, 8'h84: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // All eight conditional branches share the xxx10000 encoding
  function automatic logic is_branch(input logic [7:0] op);
    return (op[4:0] == 5'b10000);
  endfunction

  // op[7:6] picks N/V/C/Z, op[5] is the flag value that takes the branch
  function automatic logic branch_taken(input logic [7:0] op, input logic n, input logic v,
                                        input logic c, input logic z);
    logic f;
    case (op[7:6])
      2'b00:   f = n;
      2'b01:   f = v;
      2'b10:   f = c;
      default: f = z;
    endcase
    return (f == op[5]);
  endfunction

  top_6502_mem #(
    .ROM_WORDS(ROM_WORDS),
    .RAM_WORDS(RAM_WORDS)
  ) mem (
    .clk  (clk),
    .addr (mem_addr_s),
    .we   (mem_we_s),
    .wdata(mem_wdata_s),
    .rdata(mem_rdata_s)
  );

  // Bus address and store strobe; kept free of read data so there is no comb loop through mem
  always_comb begin
    mem_addr_s  = pc_r;
    mem_we_s    = 1'b0;
    mem_wdata_s = 8'h00;
    case (state_r)
      VEC_LO: mem_addr_s = 16'hFFFC;
      VEC_HI: mem_addr_s = 16'hFFFD;
      EXEC: begin
        if (is_zp(op_r)) begin
          mem_addr_s = {8'h00, opnd_r};
          case (op_r)
            8'h85: begin mem_we_s = ~reset; mem_wdata_s = a_r; end
            8'h86: begin mem_we_s = ~reset; mem_wdata_s = x_r; end
            8'h84: begin mem_we_s = ~reset; mem_wdata_s = y_r; end
            default: mem_we_s = 1'b0;
          endcase
        end else begin
          mem_addr_s = pc_r;
        end
      end
      default: mem_addr_s = pc_r;
    endcase
  end

  // Adder shared by ADC/SBC (SBC feeds ~M), and the compare subtractor
  always_comb begin
    adc_m_s    = (op_r == 8'hE9) ? ~mem_rdata_s : mem_rdata_s;
    adc_sum_s  = {1'b0, a_r} + {1'b0, adc_m_s} + {8'h00, flag_c_r};
    adc_v_s    = ~(a_r[7] ^ adc_m_s[7]) & (a_r[7] ^ adc_sum_s[7]);
    cmp_diff_s = {1'b0, a_r} + {1'b0, ~mem_rdata_s} + 9'd1;
  end

  // Next-state and datapath decode
  always_comb begin
    state_nxt  = state_r;
    pc_nxt     = pc_r;
    a_nxt      = a_r;
    x_nxt      = x_r;
    y_nxt      = y_r;
    op_nxt     = op_r;
    opnd_nxt   = opnd_r;
    flag_v_nxt = flag_v_r;
    flag_c_nxt = flag_c_r;
    halted_nxt = halted_r;
    nz_en_s    = 1'b0;
    nz_val_s   = 8'h00;
    flag_n_nxt = flag_n_r;
    flag_z_nxt = flag_z_r;
    case (state_r)
      VEC_LO: begin
        opnd_nxt  = mem_rdata_s;
        state_nxt = VEC_HI;
      end
      VEC_HI: begin
        pc_nxt    = {mem_rdata_s, opnd_r};
        state_nxt = FETCH;
      end
      FETCH: begin
        op_nxt = mem_rdata_s;
        pc_nxt = pc_r + 16'd1;
        if (is_imm(mem_rdata_s) || is_zp(mem_rdata_s) || is_branch(mem_rdata_s) ||
            (mem_rdata_s == 8'h4C)) begin
          state_nxt = OPER1;
        end else begin
          state_nxt = EXEC;
        end
      end
      OPER1: begin
        pc_nxt   = pc_r + 16'd1;
        opnd_nxt = mem_rdata_s;
        if (is_imm(op_r)) begin
          state_nxt = FETCH;
          nz_en_s   = 1'b1;
          case (op_r)
            8'hA9: begin a_nxt = mem_rdata_s; nz_val_s = mem_rdata_s; end
            8'hA2: begin x_nxt = mem_rdata_s; nz_val_s = mem_rdata_s; end
            8'hA0: begin y_nxt = mem_rdata_s; nz_val_s = mem_rdata_s; end
            8'h69, 8'hE9: begin
              a_nxt      = adc_sum_s[7:0];
              flag_c_nxt = adc_sum_s[8];
              flag_v_nxt = adc_v_s;
              nz_val_s   = adc_sum_s[7:0];
            end
            8'h29: begin a_nxt = a_r & mem_rdata_s; nz_val_s = a_r & mem_rdata_s; end
            8'h09: begin a_nxt = a_r | mem_rdata_s; nz_val_s = a_r | mem_rdata_s; end
            8'h49: begin a_nxt = a_r ^ mem_rdata_s; nz_val_s = a_r ^ mem_rdata_s; end
            8'hC9: begin flag_c_nxt = cmp_diff_s[8]; nz_val_s = cmp_diff_s[7:0]; end
            default: nz_en_s = 1'b0;
          endcase
        end else if (is_zp(op_r)) begin
          state_nxt = EXEC;
        end else if (is_branch(op_r)) begin
          if (branch_taken(op_r, flag_n_r, flag_v_r, flag_c_r, flag_z_r)) begin
            state_nxt = EXEC;
          end else begin
            state_nxt = FETCH;
          end
        end else if (op_r == 8'h4C) begin
          state_nxt = OPER2;
        end else begin
          state_nxt = FETCH;
        end
      end
      OPER2: begin
        pc_nxt    = {mem_rdata_s, opnd_r};
        state_nxt = FETCH;
      end
      EXEC: begin
        state_nxt = FETCH;
        if (is_zp(op_r)) begin
          if (op_r == 8'hA5) begin
            a_nxt    = mem_rdata_s;
            nz_en_s  = 1'b1;
            nz_val_s = mem_rdata_s;
          end else begin
            nz_en_s = 1'b0;
          end
        end else if (is_branch(op_r)) begin
          pc_nxt = pc_r + {{8{opnd_r[7]}}, opnd_r};
        end else begin
          case (op_r)
            8'hE8: begin x_nxt = x_r + 8'd1; nz_en_s = 1'b1; nz_val_s = x_r + 8'd1; end
            8'hC8: begin y_nxt = y_r + 8'd1; nz_en_s = 1'b1; nz_val_s = y_r + 8'd1; end
            8'hCA: begin x_nxt = x_r - 8'd1; nz_en_s = 1'b1; nz_val_s = x_r - 8'd1; end
            8'h88: begin y_nxt = y_r - 8'd1; nz_en_s = 1'b1; nz_val_s = y_r - 8'd1; end
            8'h18: flag_c_nxt = 1'b0;
            8'h38: flag_c_nxt = 1'b1;
            8'hB8: flag_v_nxt = 1'b0;
            8'h00: begin halted_nxt = 1'b1; state_nxt = HALT; end
            default: nz_en_s = 1'b0;
          endcase
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = VEC_LO;
    endcase
    if (nz_en_s) begin
      flag_n_nxt = nz_val_s[7];
      flag_z_nxt = (nz_val_s == 8'h00);
    end else begin
      flag_n_nxt = flag_n_r;
      flag_z_nxt = flag_z_r;
    end
  end

  // Architectural state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= VEC_LO;
      pc_r     <= 16'h0000;
      a_r      <= 8'h00;
      x_r      <= 8'h00;
      y_r      <= 8'h00;
      op_r     <= 8'h00;
      opnd_r   <= 8'h00;
      flag_n_r <= 1'b0;
      flag_v_r <= 1'b0;
      flag_z_r <= 1'b0;
      flag_c_r <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      pc_r     <= pc_nxt;
      a_r      <= a_nxt;
      x_r      <= x_nxt;
      y_r      <= y_nxt;
      op_r     <= op_nxt;
      opnd_r   <= opnd_nxt;
      flag_n_r <= flag_n_nxt;
      flag_v_r <= flag_v_nxt;
      flag_z_r <= flag_z_nxt;
      flag_c_r <= flag_c_nxt;
      halted_r <= halted_nxt;
    end
  end

  assign halted = halted_r;
  assign pc_dbg = pc_r;

`ifdef INSN_TRACE_EN
  // Per-fetch trace
  always @(posedge clk) begin
    if (!reset && state_r == FETCH) begin
      $display("pc=%04h op=%02h A=%02h X=%02h Y=%02h NVZC=%b%b%b%b", pc_r, mem_rdata_s,
               a_r, x_r, y_r, flag_n_r, flag_v_r, flag_z_r, flag_c_r);
    end
  end
`else
`endif
endmodule

// File: tb/tb_top_6502_system.sv
// Scoreboard bench for top_6502_system: expected stores are queued before each run and
// matched (address, data, NVZC) as the CPU performs them.

module tb_top_6502_system;
  logic        clk;
  logic        reset;
  logic        halted;
  logic [15:0] pc_dbg;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] nvzc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks;
  int   n_pass;
  int   rom_ptr;
  logic mon_en;
  time  t_release;
  time  t_store80;

  top_6502_system dut (
    .clk   (clk),
    .reset (reset),
    .halted(halted),
    .pc_dbg(pc_dbg)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic e1(input logic [7:0] b);
    dut.mem.ROM[rom_ptr] = b;
    rom_ptr++;
  endtask

  task automatic e2(input logic [7:0] b0, input logic [7:0] b1);
    e1(b0);
    e1(b1);
  endtask

  task automatic push_store(input logic [7:0] a, input logic [7:0] d, input logic [3:0] f);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.nvzc = f;
    sb_q.push_back(e);
  endtask

  task automatic load_rom();
    for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = 8'hEA;
    dut.mem.ROM[12'hFFC] = 8'h00;
    dut.mem.ROM[12'hFFD] = 8'hF0;
    rom_ptr = 0;
    // branch suite: taken branches skip ORA #$80, not-taken fall into ORA #bit or INY
    e2(8'hA9, 8'h7F); e2(8'h69, 8'h01); e2(8'hA9, 8'h00);
    e2(8'h70, 8'h02); e2(8'h09, 8'h80); e2(8'h50, 8'h02); e2(8'h09, 8'h01);
    e1(8'hB8);
    e2(8'h50, 8'h02); e2(8'h09, 8'h80); e2(8'h70, 8'h01); e1(8'hC8);
    e1(8'h38);
    e2(8'hB0, 8'h02); e2(8'h09, 8'h80); e2(8'h90, 8'h02); e2(8'h09, 8'h02);
    e1(8'h18);
    e2(8'h90, 8'h02); e2(8'h09, 8'h80); e2(8'hB0, 8'h01); e1(8'hC8);
    e2(8'hA2, 8'h00);
    e2(8'hF0, 8'h02); e2(8'h09, 8'h80); e2(8'hD0, 8'h02); e2(8'h09, 8'h04);
    e2(8'hA2, 8'h01);
    e2(8'hD0, 8'h02); e2(8'h09, 8'h80); e2(8'hF0, 8'h02); e2(8'h09, 8'h08);
    e2(8'h10, 8'h02); e2(8'h09, 8'h80); e2(8'h30, 8'h01); e1(8'hC8);
    e2(8'hA2, 8'h80);
    e2(8'h30, 8'h02); e2(8'h09, 8'h80); e2(8'h10, 8'h02); e2(8'h09, 8'h10);
    e2(8'h85, 8'h80); e2(8'h84, 8'h83);
    // overflow add
    e2(8'hA9, 8'h7F); e2(8'h69, 8'h01); e2(8'h85, 8'h81);
    // INX wrap and BEQ over a poison store
    e2(8'hA2, 8'hFF); e1(8'hE8); e2(8'h86, 8'h82);
    e2(8'hF0, 8'h02); e2(8'h85, 8'h84); e2(8'hA9, 8'h55); e2(8'h85, 8'h85);
    // CMP then BCC/BMI over poison stores
    e2(8'hA9, 8'h10); e2(8'hC9, 8'h20);
    e2(8'h90, 8'h02); e2(8'h85, 8'h86); e2(8'h30, 8'h02); e2(8'h85, 8'h87);
    e2(8'h86, 8'h88); e2(8'h85, 8'h89);
    // SBC/AND/EOR, DEY/DEX wrap, zero-page load, unlisted opcode, JMP
    e1(8'h38); e2(8'hA9, 8'h50); e2(8'hE9, 8'hF0); e2(8'h29, 8'h0F); e2(8'h49, 8'hFF);
    e2(8'h85, 8'h8A);
    e2(8'hA0, 8'h00); e1(8'h88); e1(8'hCA); e2(8'h86, 8'h8B);
    e2(8'hA5, 8'h80); e2(8'h84, 8'h8C); e2(8'h85, 8'h8D);
    e1(8'h02);
    e1(8'h4C); e2(8'h00, 8'hF1);
    e2(8'h85, 8'h8E);
    rom_ptr = 16'h0100;
    e1(8'h00);
  endtask

  // Store monitor: pops the scoreboard on every CPU write
  always @(negedge clk) begin
    if (mon_en && dut.mem_we_s) begin
      if (sb_q.size() == 0) begin
        check("sb_extra_store", 32'(dut.mem_addr_s), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_addr", 32'(dut.mem_addr_s), 32'({8'h00, mon_e.addr}));
        check("sb_data", 32'(dut.mem_wdata_s), 32'(mon_e.data));
        check("sb_nvzc", 32'({dut.flag_n_r, dut.flag_v_r, dut.flag_z_r, dut.flag_c_r}),
              32'(mon_e.nvzc));
        if (mon_e.addr == 8'h80) t_store80 = $time;
      end
    end
  end

  task automatic run_full();
    int cyc;
    sb_q.delete();
    push_store(8'h80, 8'h1F, 4'b0000);
    push_store(8'h83, 8'h03, 4'b0000);
    push_store(8'h81, 8'h80, 4'b1100);
    push_store(8'h82, 8'h00, 4'b0110);
    push_store(8'h85, 8'h55, 4'b0100);
    push_store(8'h88, 8'h00, 4'b1100);
    push_store(8'h89, 8'h10, 4'b1100);
    push_store(8'h8A, 8'hFF, 4'b1000);
    push_store(8'h8B, 8'hFF, 4'b1000);
    push_store(8'h8C, 8'hFF, 4'b0000);
    push_store(8'h8D, 8'h1F, 4'b0000);
    t_store80 = '1;
    @(negedge clk);
    reset     = 1'b0;
    t_release = $time;
    mon_en    = 1'b1;
    cyc       = 0;
    while (!halted && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 2) check("pc_vector", 32'(pc_dbg), 32'h0000_F000);
    end
    check("cycles_to_halt", 32'(cyc), 32'd158);
    check("halted", 32'(halted), 32'd1);
    check("pc_at_halt", 32'(pc_dbg), 32'h0000_F101);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("ram80_in_time", 32'((t_store80 - t_release) <= 64'd3800), 32'd1);
    mon_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    mon_en   = 1'b0;
    n_checks = 0;
    n_pass   = 0;
    load_rom();
    #95;
    check("rst_a", 32'(dut.a_r), 32'd0);
    check("rst_x", 32'(dut.x_r), 32'd0);
    check("rst_y", 32'(dut.y_r), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_nvzc", 32'({dut.flag_n_r, dut.flag_v_r, dut.flag_z_r, dut.flag_c_r}), 32'd0);

    run_full();
    check("ram80", 32'(dut.mem.RAM[8'h80]), 32'h1F);
    check("ram81", 32'(dut.mem.RAM[8'h81]), 32'h80);
    check("ram82", 32'(dut.mem.RAM[8'h82]), 32'h00);
    check("ram83", 32'(dut.mem.RAM[8'h83]), 32'h03);

    repeat (10) @(posedge clk);
    #1;
    check("pc_frozen", 32'(pc_dbg), 32'h0000_F101);
    check("halt_held", 32'(halted), 32'd1);
    check("a_frozen", 32'(dut.a_r), 32'h1F);

    #5;
    reset = 1'b1;
    #2;
    check("rst_clears_halt", 32'(halted), 32'd0);
    check("rst_clears_a", 32'(dut.a_r), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    check("midrun_a", 32'(dut.a_r), 32'd0);
    check("midrun_y", 32'(dut.y_r), 32'd0);
    check("midrun_halted", 32'(halted), 32'd0);
    repeat (2) @(negedge clk);
    run_full();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
